// File: rtl/fpadd_arbiter_pkg.sv
// Shared definitions for the fpadd sequencer/arbiter and its benches.
package fpadd_arbiter_pkg;

  localparam int unsigned FPADD_WIDTH       = 8;
  localparam int unsigned FPADD_HOLD_CYCLES = 10;
  localparam int unsigned FPADD_CLR_CYCLES  = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FLUSH   = 2'd3
  } fpadd_state_t;

endpackage

// File: rtl/fpadd_arbiter_rr_arb2.sv
// Two-way round-robin pick; the requester not served last wins a tie.
module rr_arb2
  import fpadd_arbiter_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  input  logic upd_idx,
  output logic any_c,
  output logic pick_c
);

  logic last_q;

  // Last-grant pointer; starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (clr) begin
      last_q <= 1'b1;
    end else if (upd) begin
      last_q <= upd_idx;
    end
  end

  // Combinational winner selection.
  always_comb begin
    any_c  = req0 | req1;
    pick_c = 1'b0;
    if (req0 && req1) begin
      pick_c = ~last_q;
    end else if (req1) begin
      pick_c = 1'b1;
    end
  end

endmodule

// File: rtl/fpadd_arbiter.sv
// Sequences the shared fpadd unit (no done flag) between two requesters.
module fpadd_arbiter
  import fpadd_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH       = FPADD_WIDTH,
  parameter int unsigned HOLD_CYCLES = FPADD_HOLD_CYCLES,
  parameter int unsigned CLR_CYCLES  = FPADD_CLR_CYCLES
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             busy,
  output logic             gnt,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             fp_start,
  output logic             fp_clr,
  output logic [WIDTH-1:0] fp_a,
  output logic [WIDTH-1:0] fp_b,
  input  logic [WIDTH-1:0] fp_s
);

  localparam int unsigned MAX_CYC = (HOLD_CYCLES > CLR_CYCLES) ? HOLD_CYCLES : CLR_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  // Zero-length windows would make the counter compare meaningless.
  if (HOLD_CYCLES < 1 || CLR_CYCLES < 1) begin : g_param_check
    $error("fpadd_arbiter: HOLD_CYCLES and CLR_CYCLES must both be at least 1");
  end

  fpadd_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             any_c, pick_c;
  logic             grant_c, capture_c, upd_c;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .clr     (clr),
    .req0    (req0),
    .req1    (req1),
    .upd     (upd_c),
    .upd_idx (gnt),
    .any_c   (any_c),
    .pick_c  (pick_c)
  );

  // fpadd is cleared both by system reset and during the flush window.
  assign fp_clr = clr | (state_q == ST_FLUSH);

  // Next-state logic and per-cycle strobes.
  always_comb begin
    state_d   = state_q;
    grant_c   = 1'b0;
    capture_c = 1'b0;
    upd_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          state_d = ST_ISSUE;
          grant_c = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d   = ST_CAPTURE;
          capture_c = 1'b1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_FLUSH;
        upd_c   = 1'b1;
      end
      ST_FLUSH: begin
        if (cnt_q == CNT_W'(CLR_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and window counter; counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || state_q == ST_IDLE) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Registered outputs: grant/operand latch, start window, capture and done.
  always_ff @(posedge clk) begin
    if (clr) begin
      busy     <= 1'b0;
      gnt      <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      result   <= '0;
      fp_start <= 1'b0;
      fp_a     <= '0;
      fp_b     <= '0;
    end else begin
      busy     <= (state_d != ST_IDLE);
      fp_start <= (state_d == ST_ISSUE);
      done0    <= capture_c & ~gnt;
      done1    <= capture_c & gnt;
      if (grant_c) begin
        gnt  <= pick_c;
        fp_a <= pick_c ? a1 : a0;
        fp_b <= pick_c ? b1 : b0;
      end
      if (capture_c) begin
        result <= fp_s;
      end
    end
  end

endmodule
